// File: rtl/execute_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution with a
// combinational fetch redirect, and the registered bundle for the memory stage.
module execute_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] i_pipe_PC,
  input  logic [XLEN-1:0] i_pipe_Imm,
  input  logic [XLEN-1:0] i_pipe_Reg1Data,
  input  logic [XLEN-1:0] i_pipe_Reg2Data,
  input  logic [4:0]      i_pipe_Reg1,
  input  logic [4:0]      i_pipe_Reg2,
  input  logic [4:0]      i_pipe_RegDst,
  input  logic            i_pipe_Alu1Src,
  input  logic [1:0]      i_pipe_Alu2Src,
  input  logic [3:0]      i_pipe_AluCtr,
  input  logic            i_pipe_MemToReg,
  input  logic            i_pipe_RegWrEn,
  input  logic            i_pipe_MemWrEn,
  input  logic            i_pipe_Branch,
  input  logic            i_pipe_Jump,
  input  logic            i_pipe_JumpReg,
  input  logic            i_MemFwdEn,
  input  logic [4:0]      i_MemFwdDst,
  input  logic [XLEN-1:0] i_MemFwdData,
  input  logic            i_RegWrEn,
  input  logic [4:0]      i_RegDst,
  input  logic [XLEN-1:0] i_RegWrData,
  input  logic            i_stall,
  output logic            o_Redirect,
  output logic [XLEN-1:0] o_RedirectPC,
  output logic [XLEN-1:0] o_pipe_AluResult,
  output logic [XLEN-1:0] o_pipe_StoreData,
  output logic [4:0]      o_pipe_RegDst,
  output logic [XLEN-1:0] o_pipe_PC,
  output logic            o_pipe_MemToReg,
  output logic            o_pipe_RegWrEn,
  output logic            o_pipe_MemWrEn
);

  logic [XLEN-1:0] fwd_rs1, fwd_rs2, op_a, op_b, alu_result, target;
  logic            squash, taken;

  // MEM beats WB because it holds the younger write; x0 is hardwired to zero.
  always_comb begin
    fwd_rs1 = i_pipe_Reg1Data;
    if (i_pipe_Reg1 == 5'd0)
      fwd_rs1 = '0;
    else if (i_MemFwdEn && i_MemFwdDst == i_pipe_Reg1)
      fwd_rs1 = i_MemFwdData;
    else if (i_RegWrEn && i_RegDst == i_pipe_Reg1)
      fwd_rs1 = i_RegWrData;
  end

  always_comb begin
    fwd_rs2 = i_pipe_Reg2Data;
    if (i_pipe_Reg2 == 5'd0)
      fwd_rs2 = '0;
    else if (i_MemFwdEn && i_MemFwdDst == i_pipe_Reg2)
      fwd_rs2 = i_MemFwdData;
    else if (i_RegWrEn && i_RegDst == i_pipe_Reg2)
      fwd_rs2 = i_RegWrData;
  end

  always_comb begin
    op_a = i_pipe_Alu1Src ? i_pipe_PC : fwd_rs1;
    case (i_pipe_Alu2Src)
      2'b00:   op_b = fwd_rs2;
      2'b10:   op_b = XLEN'(4);
      default: op_b = i_pipe_Imm;
    endcase
  end

  always_comb begin
    alu_result = '0;
    case (i_pipe_AluCtr)
      4'd0:  alu_result = op_a + op_b;
      4'd1:  alu_result = op_a - op_b;
      4'd2:  alu_result = op_a << op_b[4:0];
      4'd3:  alu_result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      4'd4:  alu_result = {{(XLEN-1){1'b0}}, op_a < op_b};
      4'd5:  alu_result = op_a ^ op_b;
      4'd6:  alu_result = op_a >> op_b[4:0];
      4'd7:  alu_result = XLEN'($signed(op_a) >>> op_b[4:0]);
      4'd8:  alu_result = op_a | op_b;
      4'd9:  alu_result = op_a & op_b;
      4'd10: alu_result = {{(XLEN-1){1'b0}}, op_a == op_b};
      4'd11: alu_result = {{(XLEN-1){1'b0}}, op_a != op_b};
      4'd12: alu_result = {{(XLEN-1){1'b0}}, $signed(op_a) >= $signed(op_b)};
      4'd13: alu_result = {{(XLEN-1){1'b0}}, op_a >= op_b};
      4'd14: alu_result = op_b;
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    taken = !squash && ((i_pipe_Branch && alu_result[0]) || i_pipe_Jump);
    if (i_pipe_Jump && i_pipe_JumpReg)
      target = (fwd_rs1 + i_pipe_Imm) & {{(XLEN-1){1'b1}}, 1'b0};
    else
      target = i_pipe_PC + i_pipe_Imm;
    o_Redirect   = taken && !i_stall && !reset;
    o_RedirectPC = o_Redirect ? target : '0;
  end

  // The squash flag marks the one wrong-path instruction behind a redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      squash           <= 1'b0;
      o_pipe_AluResult <= '0;
      o_pipe_StoreData <= '0;
      o_pipe_RegDst    <= '0;
      o_pipe_PC        <= '0;
      o_pipe_MemToReg  <= 1'b0;
      o_pipe_RegWrEn   <= 1'b0;
      o_pipe_MemWrEn   <= 1'b0;
    end else begin
      if (o_Redirect)
        squash <= 1'b1;
      else if (!i_stall)
        squash <= 1'b0;
      if (!i_stall) begin
        if (squash) begin
          o_pipe_AluResult <= '0;
          o_pipe_StoreData <= '0;
          o_pipe_RegDst    <= '0;
          o_pipe_PC        <= '0;
          o_pipe_MemToReg  <= 1'b0;
          o_pipe_RegWrEn   <= 1'b0;
          o_pipe_MemWrEn   <= 1'b0;
        end else begin
          o_pipe_AluResult <= alu_result;
          o_pipe_StoreData <= fwd_rs2;
          o_pipe_RegDst    <= i_pipe_RegDst;
          o_pipe_PC        <= i_pipe_PC;
          o_pipe_MemToReg  <= i_pipe_MemToReg;
          o_pipe_RegWrEn   <= i_pipe_RegWrEn;
          o_pipe_MemWrEn   <= i_pipe_MemWrEn;
        end
      end
    end
  end

endmodule
